// File: rtl/ccip_arb_pkg.sv
// Shared CCI-P arbitration definitions: mdata layout and requester-ID helpers.
// mdata carries {requester id, per-requester tag} so responses can be routed back.
package ccip_arb_pkg;

   localparam int unsigned MDATA_ID_W  = 3;
   localparam int unsigned MDATA_TAG_W = 13;
   localparam int unsigned MDATA_W     = MDATA_ID_W + MDATA_TAG_W;

   typedef logic [MDATA_ID_W-1:0]  t_req_id;
   typedef logic [MDATA_TAG_W-1:0] t_req_tag;

   typedef struct packed {
      t_req_id  id;
      t_req_tag tag;
   } t_mdata;

   function automatic logic [MDATA_W-1:0] pack_mdata(input t_req_id id, input t_req_tag tag);
      t_mdata m;
      m.id  = id;
      m.tag = tag;
      return m;
   endfunction

   function automatic t_req_id mdata_id(input logic [MDATA_W-1:0] mdata);
      t_mdata m;
      m = mdata;
      return m.id;
   endfunction

   function automatic t_req_tag mdata_tag(input logic [MDATA_W-1:0] mdata);
      t_mdata m;
      m = mdata;
      return m.tag;
   endfunction

endpackage

// File: rtl/ccip_c1_wr_arbiter_if.sv
// Requester-side and c1 Tx/Rx signal bundle for the c1 write arbiter.
// master = requesters plus shell, slave = arbiter.
interface ccip_c1_wr_arbiter_if #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ADDR_W  = 42,
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned MDATA_W = 16,
   parameter int unsigned CNT_W   = 7
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ*13-1:0]     req_tag;

   logic                    c1_alm_full;
   logic                    c1_tx_valid;
   logic [ADDR_W-1:0]       c1_tx_addr;
   logic [DATA_W-1:0]       c1_tx_data;
   logic [MDATA_W-1:0]      c1_tx_mdata;

   logic                    c1_rsp_valid;
   logic [MDATA_W-1:0]      c1_rsp_mdata;
   logic [N_REQ-1:0]        rsp_valid;
   logic [12:0]             rsp_tag;

   logic [CNT_W-1:0]        outstanding;
   logic                    err_underflow;

   modport master (
      output req_valid, req_addr, req_data, req_tag, c1_alm_full, c1_rsp_valid, c1_rsp_mdata,
      input  req_ready, c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
             rsp_valid, rsp_tag, outstanding, err_underflow
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_tag, c1_alm_full, c1_rsp_valid, c1_rsp_mdata,
      output req_ready, c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata,
             rsp_valid, rsp_tag, outstanding, err_underflow
   );
endinterface

// File: rtl/ccip_c1_wr_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searching upward from rr_ptr.
// The pointer advances past the winner whenever a grant is issued.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] idx;
   logic             found;
   int unsigned      sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   // Scan N positions starting at rr_ptr, wrapping modulo N.
   always_comb begin
      grant    = '0;
      rr_ptr_d = rr_ptr_q;
      found    = 1'b0;
      idx      = '0;
      sum      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = 32'(rr_ptr_q) + k;
         if (sum >= N) sum = sum - N;
         idx = PTR_W'(sum);
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            rr_ptr_d   = (sum == N - 1) ? '0 : PTR_W'(sum + 1);
         end
      end
   end

endmodule

// File: rtl/ccip_c1_wr_arbiter.sv
// Shares the CCI-P c1 write Tx channel among N_REQ requesters with credit and
// almost-full gating; tags mdata with the requester id and routes responses back.
module ccip_c1_wr_arbiter
   import ccip_arb_pkg::*;
#(
   parameter int unsigned N_REQ           = 4,
   parameter int unsigned MAX_OUTSTANDING = 64,
   parameter int unsigned ADDR_W          = 42,
   parameter int unsigned DATA_W          = 512,
   parameter int unsigned MDATA_W         = 16
) (
   input logic                  clk,
   input logic                  reset,
   ccip_c1_wr_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [N_REQ-1:0]   grant_c;
   logic               en_c;
   logic               hs_c;
   t_req_id            gnt_id_c;
   logic [ADDR_W-1:0]  sel_addr_c;
   logic [DATA_W-1:0]  sel_data_c;
   t_req_tag           sel_tag_c;
   logic               dec_c;

   logic               tx_valid_q, tx_valid_d;
   logic [ADDR_W-1:0]  tx_addr_q,  tx_addr_d;
   logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
   logic [MDATA_W-1:0] tx_mdata_q, tx_mdata_d;
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   t_req_tag           rsp_tag_q,  rsp_tag_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               err_q,      err_d;

   // Reset also blocks grants so req_ready reads zero while reset is held.
   assign en_c = !reset && !bus.c1_alm_full && (cnt_q < CNT_W'(MAX_OUTSTANDING));

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (bus.req_valid),
      .en    (en_c),
      .grant (grant_c)
   );

   assign hs_c          = |grant_c;
   assign bus.req_ready = grant_c;

   // One-hot grant selects the winning requester's payload.
   always_comb begin
      gnt_id_c   = '0;
      sel_addr_c = '0;
      sel_data_c = '0;
      sel_tag_c  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_c[i]) begin
            gnt_id_c   = MDATA_ID_W'(i);
            sel_addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data_c = bus.req_data[i*DATA_W +: DATA_W];
            sel_tag_c  = bus.req_tag[i*MDATA_TAG_W +: MDATA_TAG_W];
         end
      end
   end

   always_comb begin
      tx_valid_d  = hs_c;
      tx_addr_d   = tx_addr_q;
      tx_data_d   = tx_data_q;
      tx_mdata_d  = tx_mdata_q;
      rsp_valid_d = '0;
      rsp_tag_d   = rsp_tag_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      dec_c       = bus.c1_rsp_valid && (cnt_q != '0);

      if (hs_c) begin
         tx_addr_d  = sel_addr_c;
         tx_data_d  = sel_data_c;
         tx_mdata_d = MDATA_W'(pack_mdata(gnt_id_c, sel_tag_c));
      end

      // Ids beyond N_REQ match no strobe but still return a credit.
      if (bus.c1_rsp_valid) begin
         rsp_tag_d = mdata_tag(bus.c1_rsp_mdata);
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (mdata_id(bus.c1_rsp_mdata) == MDATA_ID_W'(i)) rsp_valid_d[i] = 1'b1;
         end
         if (cnt_q == '0) err_d = 1'b1;
      end

      if (hs_c && !dec_c)      cnt_d = cnt_q + 1'b1;
      else if (!hs_c && dec_c) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_valid_q  <= 1'b0;
         tx_addr_q   <= '0;
         tx_data_q   <= '0;
         tx_mdata_q  <= '0;
         rsp_valid_q <= '0;
         rsp_tag_q   <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         tx_valid_q  <= tx_valid_d;
         tx_addr_q   <= tx_addr_d;
         tx_data_q   <= tx_data_d;
         tx_mdata_q  <= tx_mdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q   <= rsp_tag_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

   assign bus.c1_tx_valid   = tx_valid_q;
   assign bus.c1_tx_addr    = tx_addr_q;
   assign bus.c1_tx_data    = tx_data_q;
   assign bus.c1_tx_mdata   = tx_mdata_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_tag       = rsp_tag_q;
   assign bus.outstanding   = cnt_q;
   assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ccip_c1_wr_arbiter.sv
// Directed bench for ccip_c1_wr_arbiter with hand-computed expectations.
module tb_ccip_c1_wr_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ADDR_W = 42;
   localparam int unsigned DATA_W = 512;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   ccip_c1_wr_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(16), .CNT_W(7)) bus_if ();

   ccip_c1_wr_arbiter #(.N_REQ(N_REQ), .MAX_OUTSTANDING(64), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_mdata(input int r);
      return {3'(r), 13'(13'h100 + r)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      bus_if.req_valid    = '0;
      bus_if.c1_alm_full  = 1'b0;
      bus_if.c1_rsp_valid = 1'b0;
      bus_if.c1_rsp_mdata = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      n_tests++;
      if ({bus_if.c1_tx_valid, bus_if.c1_tx_mdata, bus_if.rsp_valid, bus_if.rsp_tag, bus_if.err_underflow} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got tx_v=%0b mdata=%h rsp=%b tag=%h err=%0b want all 0",
            bus_if.c1_tx_valid, bus_if.c1_tx_mdata, bus_if.rsp_valid, bus_if.rsp_tag, bus_if.err_underflow);
      end
      n_tests++;
      if (bus_if.outstanding !== 7'd0 || bus_if.req_ready !== 4'b0 || bus_if.c1_tx_addr !== '0) begin
         n_fail++; $display("FAIL reset_cnt_ready got cnt=%0d ready=%b addr=%h want 0", bus_if.outstanding, bus_if.req_ready, bus_if.c1_tx_addr);
      end
      do_reset();
   endtask

   task automatic test_round_robin;
      logic [3:0] exp;
      do_reset();
      bus_if.req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1;
         exp = 4'b1 << (k % 4);
         n_tests++;
         if (bus_if.req_ready !== exp) begin
            n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", k, bus_if.req_ready, exp);
         end
         tick();
         n_tests++;
         if (bus_if.c1_tx_valid !== 1'b1 || bus_if.c1_tx_mdata !== exp_mdata(k % 4)) begin
            n_fail++; $display("FAIL rr_tx[%0d] got v=%0b mdata=%h want v=1 mdata=%h", k, bus_if.c1_tx_valid, bus_if.c1_tx_mdata, exp_mdata(k % 4));
         end
         n_tests++;
         if (bus_if.c1_tx_addr !== 42'(42'h1000 + k % 4) || bus_if.c1_tx_data !== {16{32'(32'hD000_0000 + k % 4)}}) begin
            n_fail++; $display("FAIL rr_payload[%0d] got addr=%h want %h", k, bus_if.c1_tx_addr, 42'(42'h1000 + k % 4));
         end
      end
      bus_if.req_valid = '0;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0) begin
         n_fail++; $display("FAIL rr_idle_ready got %b want 0000", bus_if.req_ready);
      end
      tick();
      n_tests++;
      if (bus_if.c1_tx_valid !== 1'b0 || bus_if.c1_tx_mdata !== exp_mdata(0) || bus_if.outstanding !== 7'd5) begin
         n_fail++; $display("FAIL rr_drain got v=%0b mdata=%h cnt=%0d want v=0 mdata=%h cnt=5",
            bus_if.c1_tx_valid, bus_if.c1_tx_mdata, bus_if.outstanding, exp_mdata(0));
      end
   endtask

   task automatic test_sparse;
      logic [3:0] exp;
      do_reset();
      bus_if.req_valid = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp = (k % 2 == 1) ? 4'b0100 : 4'b0001;
         n_tests++;
         if (bus_if.req_ready !== exp) begin
            n_fail++; $display("FAIL sparse_ready[%0d] got %b want %b", k, bus_if.req_ready, exp);
         end
         tick();
         n_tests++;
         if (bus_if.c1_tx_mdata !== exp_mdata((k % 2) * 2)) begin
            n_fail++; $display("FAIL sparse_mdata[%0d] got %h want %h", k, bus_if.c1_tx_mdata, exp_mdata((k % 2) * 2));
         end
      end
      bus_if.req_valid = '0;
      tick();
   endtask

   task automatic test_alm_full;
      do_reset();
      bus_if.req_valid = 4'hF;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL almf_first got %b want 0001", bus_if.req_ready);
      end
      tick();
      bus_if.c1_alm_full = 1'b1;
      for (int w = 0; w < 5; w++) begin
         #1;
         n_tests++;
         if (bus_if.req_ready !== 4'b0 || bus_if.c1_tx_valid !== (w == 0)) begin
            n_fail++; $display("FAIL almf_block[%0d] got ready=%b v=%0b want ready=0000 v=%0b", w, bus_if.req_ready, bus_if.c1_tx_valid, w == 0);
         end
         tick();
      end
      bus_if.c1_alm_full = 1'b0;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL almf_resume got %b want 0010", bus_if.req_ready);
      end
      tick();
      n_tests++;
      if (bus_if.c1_tx_valid !== 1'b1 || bus_if.c1_tx_mdata !== exp_mdata(1)) begin
         n_fail++; $display("FAIL almf_resume_tx got v=%0b mdata=%h want v=1 mdata=%h", bus_if.c1_tx_valid, bus_if.c1_tx_mdata, exp_mdata(1));
      end
      bus_if.req_valid = '0;
      tick();
   endtask

   task automatic test_credit_limit;
      do_reset();
      bus_if.req_valid = 4'hF;
      repeat (64) tick();
      n_tests++;
      if (bus_if.outstanding !== 7'd64 || bus_if.req_ready !== 4'b0 || bus_if.c1_tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL credit_full got cnt=%0d ready=%b v=%0b want cnt=64 ready=0000 v=1",
            bus_if.outstanding, bus_if.req_ready, bus_if.c1_tx_valid);
      end
      bus_if.c1_rsp_valid = 1'b1;
      bus_if.c1_rsp_mdata = 16'h4005;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0) begin
         n_fail++; $display("FAIL credit_same_cycle got %b want 0000", bus_if.req_ready);
      end
      tick();
      bus_if.c1_rsp_valid = 1'b0;
      n_tests++;
      if (bus_if.rsp_valid !== 4'b0100 || bus_if.rsp_tag !== 13'd5 || bus_if.outstanding !== 7'd63 || bus_if.c1_tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL credit_rsp got rsp=%b tag=%0d cnt=%0d v=%0b want rsp=0100 tag=5 cnt=63 v=0",
            bus_if.rsp_valid, bus_if.rsp_tag, bus_if.outstanding, bus_if.c1_tx_valid);
      end
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL credit_regrant got %b want 0001", bus_if.req_ready);
      end
      tick();
      n_tests++;
      if (bus_if.outstanding !== 7'd64 || bus_if.req_ready !== 4'b0 || bus_if.rsp_valid !== 4'b0 || bus_if.c1_tx_mdata !== exp_mdata(0)) begin
         n_fail++; $display("FAIL credit_refull got cnt=%0d ready=%b rsp=%b mdata=%h want cnt=64 ready=0000 rsp=0000 mdata=%h",
            bus_if.outstanding, bus_if.req_ready, bus_if.rsp_valid, bus_if.c1_tx_mdata, exp_mdata(0));
      end
      bus_if.req_valid = '0;
      tick();
   endtask

   task automatic test_counter_edges;
      do_reset();
      bus_if.req_valid = 4'hF;
      repeat (10) tick();
      bus_if.req_valid = 4'b0001;
      bus_if.c1_rsp_valid = 1'b1;
      bus_if.c1_rsp_mdata = 16'h0007;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0001 || bus_if.outstanding !== 7'd10) begin
         n_fail++; $display("FAIL both_pre got ready=%b cnt=%0d want ready=0001 cnt=10", bus_if.req_ready, bus_if.outstanding);
      end
      tick();
      bus_if.req_valid = '0;
      n_tests++;
      if (bus_if.outstanding !== 7'd10 || bus_if.rsp_valid !== 4'b0001 || bus_if.rsp_tag !== 13'd7) begin
         n_fail++; $display("FAIL both_same_cycle got cnt=%0d rsp=%b tag=%0d want cnt=10 rsp=0001 tag=7",
            bus_if.outstanding, bus_if.rsp_valid, bus_if.rsp_tag);
      end
      bus_if.c1_rsp_mdata = 16'hA003;
      tick();
      bus_if.c1_rsp_valid = 1'b0;
      n_tests++;
      if (bus_if.outstanding !== 7'd9 || bus_if.rsp_valid !== 4'b0 || bus_if.rsp_tag !== 13'd3 || bus_if.err_underflow !== 1'b0) begin
         n_fail++; $display("FAIL bad_id got cnt=%0d rsp=%b tag=%0d err=%0b want cnt=9 rsp=0000 tag=3 err=0",
            bus_if.outstanding, bus_if.rsp_valid, bus_if.rsp_tag, bus_if.err_underflow);
      end
      do_reset();
      bus_if.c1_rsp_valid = 1'b1;
      bus_if.c1_rsp_mdata = 16'h2001;
      tick();
      bus_if.c1_rsp_valid = 1'b0;
      n_tests++;
      if (bus_if.err_underflow !== 1'b1 || bus_if.outstanding !== 7'd0 || bus_if.rsp_valid !== 4'b0010) begin
         n_fail++; $display("FAIL underflow got err=%0b cnt=%0d rsp=%b want err=1 cnt=0 rsp=0010",
            bus_if.err_underflow, bus_if.outstanding, bus_if.rsp_valid);
      end
      repeat (2) tick();
      n_tests++;
      if (bus_if.err_underflow !== 1'b1) begin
         n_fail++; $display("FAIL underflow_sticky got %0b want 1", bus_if.err_underflow);
      end
   endtask

   task automatic test_mid_reset;
      do_reset();
      bus_if.req_valid = 4'hF;
      repeat (20) tick();
      n_tests++;
      if (bus_if.outstanding !== 7'd20) begin
         n_fail++; $display("FAIL midrst_pre got cnt=%0d want 20", bus_if.outstanding);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (bus_if.c1_tx_valid !== 1'b0 || bus_if.c1_tx_addr !== '0 || bus_if.c1_tx_mdata !== 16'h0 ||
          bus_if.c1_tx_data !== '0 || bus_if.outstanding !== 7'd0 || bus_if.req_ready !== 4'b0) begin
         n_fail++; $display("FAIL midrst_async got v=%0b addr=%h mdata=%h cnt=%0d ready=%b want all 0",
            bus_if.c1_tx_valid, bus_if.c1_tx_addr, bus_if.c1_tx_mdata, bus_if.outstanding, bus_if.req_ready);
      end
      tick();
      reset = 1'b0;
      #1;
      n_tests++;
      if (bus_if.req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL midrst_first got %b want 0001", bus_if.req_ready);
      end
      tick();
      bus_if.req_valid = '0;
      n_tests++;
      if (bus_if.c1_tx_valid !== 1'b1 || bus_if.c1_tx_mdata !== exp_mdata(0) || bus_if.outstanding !== 7'd1) begin
         n_fail++; $display("FAIL midrst_restart got v=%0b mdata=%h cnt=%0d want v=1 mdata=%h cnt=1",
            bus_if.c1_tx_valid, bus_if.c1_tx_mdata, bus_if.outstanding, exp_mdata(0));
      end
      tick();
   endtask

   initial begin
      bus_if.req_valid    = '0;
      bus_if.c1_alm_full  = 1'b0;
      bus_if.c1_rsp_valid = 1'b0;
      bus_if.c1_rsp_mdata = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         bus_if.req_addr[i*ADDR_W +: ADDR_W] = 42'(42'h1000 + i);
         bus_if.req_data[i*DATA_W +: DATA_W] = {16{32'(32'hD000_0000 + i)}};
         bus_if.req_tag[i*13 +: 13]          = 13'(13'h100 + i);
      end
      test_reset();
      test_round_robin();
      test_sparse();
      test_alm_full();
      test_credit_limit();
      test_counter_edges();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
